// File: rtl/div_unit_if.sv
// div_unit_if -- EX <-> divider request/response bundle.
//
// The EX stage (master) raises start_i with the operands and the signedness
// flag, may pulse annul_i to abandon a division, and waits for ready_o. The
// divider (slave) returns {remainder, quotient} on result_o.
//
// Signals:
//   signed_div_i  EX -> div   1 = DIV (signed), 0 = DIVU (unsigned)
//   opdata1_i     EX -> div   dividend, WIDTH bits
//   opdata2_i     EX -> div   divisor, WIDTH bits
//   start_i       EX -> div   request, held until the result is consumed
//   annul_i       EX -> div   abort an in-flight division
//   result_o      div -> EX   [2W-1:W] remainder (HI), [W-1:0] quotient (LO)
//   ready_o       div -> EX   result valid
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic                   signed_div_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   start_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_unit.sv
// div_unit -- multi-cycle radix-2 restoring divider for DIV/DIVU.
//
// One quotient bit is produced per clock. Operands are reduced to magnitudes
// at accept time and the signs are re-applied once the iterations finish.
// The result is held for as long as start_i stays high; dropping start_i
// returns the unit to FREE and clears the outputs.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   div_unit_if.slave (signed_div_i, opdata1_i, opdata2_i, start_i,
//         annul_i in; result_o, ready_o out, both registered)
//
// Parameters:
//   WIDTH  operand width (result is 2*WIDTH)
//   CNT_W  iteration counter width, must be able to hold WIDTH
//
// Optional feature, macro DIV_BYZERO_DETECT_EN:
//   defined   -> a zero divisor short-cuts through BYZERO and yields result 0
//                with ready_o high two cycles after accept.
//   undefined -> a zero divisor runs all WIDTH iterations (quotient all ones,
//                remainder = dividend magnitude, usual sign fix-up).
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    // {partial remainder (WIDTH+1 bits), dividend/quotient (WIDTH bits)}
    logic [2*WIDTH:0]     work_reg;
    logic [WIDTH-1:0]     divisor_reg;
    logic                 signed_reg;
    logic                 neg1_reg;
    logic                 neg2_reg;
    logic [2*WIDTH-1:0]   result_reg;
    logic                 ready_reg;

    assign bus.result_o = result_reg;
    assign bus.ready_o  = ready_reg;

    // Operand magnitudes, evaluated on the accept edge only.
    logic                 op1_neg;
    logic                 op2_neg;
    logic [WIDTH-1:0]     op1_mag;
    logic [WIDTH-1:0]     op2_mag;

    always_comb begin
        op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
        op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
        op1_mag = op1_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
        op2_mag = op2_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
    end

    // One restoring step: shift left, trial-subtract the divisor from the
    // upper WIDTH+1 bits, keep the difference and shift in 1 if it did not
    // borrow. The pre-shift remainder is always below the divisor (or, for a
    // zero divisor, below 2^WIDTH), so bit WIDTH of a successful trial is 0
    // and that bit alone signals the borrow.
    logic [2*WIDTH:0]     shifted;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH:0]     work_next;

    always_comb begin
        shifted   = work_reg << 1;
        trial     = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_reg};
        work_next = shifted;
        if (!trial[WIDTH]) begin
            work_next[2*WIDTH:WIDTH] = trial;
            work_next[0]             = 1'b1;
        end
    end

    // Sign fix-up: quotient takes the XOR of the signs, remainder follows
    // the dividend (truncating division).
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    always_comb begin
        quot_fix = work_reg[WIDTH-1:0];
        rem_fix  = work_reg[2*WIDTH-1:WIDTH];
        if (signed_reg && (neg1_reg ^ neg2_reg)) begin
            quot_fix = ~work_reg[WIDTH-1:0] + 1'b1;
        end
        if (signed_reg && neg1_reg) begin
            rem_fix = ~work_reg[2*WIDTH-1:WIDTH] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= FREE;
            cnt_reg     <= '0;
            work_reg    <= '0;
            divisor_reg <= '0;
            signed_reg  <= 1'b0;
            neg1_reg    <= 1'b0;
            neg2_reg    <= 1'b0;
            result_reg  <= '0;
            ready_reg   <= 1'b0;
        end else begin
            case (state_reg)
                FREE: begin
                    result_reg <= '0;
                    ready_reg  <= 1'b0;
                    if (bus.start_i && !bus.annul_i) begin
                        cnt_reg     <= '0;
                        work_reg    <= {{(WIDTH+1){1'b0}}, op1_mag};
                        divisor_reg <= op2_mag;
                        signed_reg  <= bus.signed_div_i;
                        neg1_reg    <= op1_neg;
                        neg2_reg    <= op2_neg;
`ifdef DIV_BYZERO_DETECT_EN
                        state_reg   <= (bus.opdata2_i == '0) ? BYZERO : ON;
`else
                        state_reg   <= ON;
`endif
                    end
                end

                BYZERO: begin
                    if (bus.annul_i) begin
                        state_reg  <= FREE;
                        result_reg <= '0;
                        ready_reg  <= 1'b0;
                    end else begin
                        // Zeroed work register makes the fix-up yield 0.
                        work_reg  <= '0;
                        state_reg <= END;
                    end
                end

                ON: begin
                    if (bus.annul_i) begin
                        state_reg  <= FREE;
                        result_reg <= '0;
                        ready_reg  <= 1'b0;
                    end else begin
                        work_reg <= work_next;
                        cnt_reg  <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                            state_reg <= END;
                        end
                    end
                end

                END: begin
                    // annul_i is deliberately ignored here; only start_i
                    // dropping releases the result.
                    if (bus.start_i) begin
                        result_reg <= {rem_fix, quot_fix};
                        ready_reg  <= 1'b1;
                    end else begin
                        state_reg  <= FREE;
                        cnt_reg    <= '0;
                        result_reg <= '0;
                        ready_reg  <= 1'b0;
                    end
                end

                default: begin
                    state_reg  <= FREE;
                    result_reg <= '0;
                    ready_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    localparam int W = 32;

    logic clk;
    logic rst;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DIV_BYZERO_DETECT_EN
    localparam bit BYZ = 1'b1;
`else
    localparam bit BYZ = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with truncation toward zero.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r, ma;
        if (b == 32'd0) begin
            if (BYZ) return 64'd0;
            if (!s) return {a, 32'hFFFF_FFFF};
            sa = longint'($signed(a));
            ma = (sa < 0) ? -sa : sa;
            q  = (sa < 0) ? -longint'(64'hFFFF_FFFF) : longint'(64'hFFFF_FFFF);
            r  = (sa < 0) ? -ma : ma;
            return {r[31:0], q[31:0]};
        end
        if (!s) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
        return (BYZ && b == 32'd0) ? 2 : W + 1;
    endfunction

    task automatic wait_ready(output int lat);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Must be called in the low phase of clk. Accept happens on the next edge.
    task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input bit scramble);
        int lat;
        logic [63:0] res;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = s;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        @(posedge clk);
        #1;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            if (scramble) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            if (bus.ready_o === 1'b1) begin
                lat = i;
                break;
            end
        end
        res = bus.result_o;
        $display("%s: a=%h b=%h s=%0d latency=%0d result=%h expected=%h", name, a, b, s, lat, res, exp);
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat(b)));
        chk({name, "_result"}, res, exp);
        @(posedge clk);
        #1;
        chk({name, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
        chk({name, "_hold_result"}, bus.result_o, exp);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_drop_ready"}, 64'(bus.ready_o), 64'd0);
        chk({name, "_drop_result"}, bus.result_o, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] ra, rb;
        logic        rs;

        vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'h0000_000E, 32'h0000_0002};
        vecs[1]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[2]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000};
        vecs[3]  = BYZ ? '{32'd5, 32'd0, 1'b0, 32'h0, 32'h0}
                       : '{32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0005};
        vecs[4]  = '{32'hFFFF_FFF9, 32'd2,         1'b0, 32'h7FFF_FFFC, 32'h0000_0001};
        vecs[5]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h0000_0001};
        vecs[6]  = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'h0000_0003, 32'hFFFF_FFFF};
        vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 32'h0000_0000};
        vecs[8]  = '{32'd3,         32'd5,         1'b0, 32'h0000_0000, 32'h0000_0003};
        vecs[9]  = BYZ ? '{32'hFFFF_FFFB, 32'd0, 1'b1, 32'h0, 32'h0}
                       : '{32'hFFFF_FFFB, 32'd0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFB};
        vecs[10] = '{32'h1234_5678, 32'h0000_1000, 1'b0, 32'h0001_2345, 32'h0000_0678};
        vecs[11] = '{32'h8000_0000, 32'd1,         1'b1, 32'h8000_0000, 32'h0000_0000};

        rst = 1'b1;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 64'(bus.ready_o), 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_ready", 64'(bus.ready_o), 64'd0);
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            do_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                   {vecs[i].r, vecs[i].q}, 1'b0);
        end

        // Operand stability: inputs scrambled every cycle after accept.
        do_div("stable_u", 32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 1'b1);
        do_div("stable_s", 32'hFFFF_FC18, 32'd7, 1'b1, ref_div(32'hFFFF_FC18, 32'd7, 1'b1), 1'b1);

        // Annul mid-division: no ready, unit returns to FREE.
        bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3; bus.signed_div_i = 1'b0;
        bus.start_i = 1'b1; bus.annul_i = 1'b0;
        @(posedge clk);            // accept, cycle 0
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);            // cycle 10
        @(negedge clk);
        bus.annul_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o !== 1'b0) seen++;
        end
        $display("annul: ready cycles after annul=%0d", seen);
        chk("annul_no_ready", 64'(seen), 64'd0);
        @(negedge clk);
        do_div("after_annul", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 1'b0);

        // start with annul held in FREE must not be accepted.
        bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd5; bus.signed_div_i = 1'b0;
        bus.start_i = 1'b1; bus.annul_i = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        do_div("annul_in_free", 32'd9, 32'd4, 1'b0, {32'd1, 32'd2}, 1'b0);

        // Reset during ON, then restart with start held high.
        bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3; bus.signed_div_i = 1'b0;
        bus.start_i = 1'b1;
        @(posedge clk);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        $display("reset_mid_on: ready=%0d result=%h", bus.ready_o, bus.result_o);
        chk("rst_on_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_on_result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_div("after_rst", 32'd77, 32'd5, 1'b0, {32'd2, 32'd15}, 1'b0);

        // Reset while the result is being held.
        bus.opdata1_i = 32'd20; bus.opdata2_i = 32'd6; bus.signed_div_i = 1'b0;
        bus.start_i = 1'b1;
        @(posedge clk);
        wait_ready(lat);
        chk("rst_end_reached", 64'(lat), 64'(W + 1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        $display("reset_in_end: ready=%0d result=%h", bus.ready_o, bus.result_o);
        chk("rst_end_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_end_result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);

        // Randomized against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                3: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            do_div($sformatf("rnd%0d", i), ra, rb, rs, ref_div(ra, rb, rs), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
